// File: rtl/tt_um_unload.sv
// Weight-readback transmitter: streams a header word and then one packed
// ternary row per word over a valid/ready handshake.
module tt_um_unload #(
  parameter int unsigned MAX_IN_LEN  = 16,
  parameter int unsigned MAX_OUT_LEN = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   ena,
  input  logic [6:0]                             ui_param,
  input  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0]    ui_weights,
  input  logic                                   ui_ready,
  output logic [15:0]                            uo_data,
  output logic                                   uo_valid,
  output logic                                   uo_busy,
  output logic                                   uo_done
);

  localparam int unsigned ROW_W  = 2 * MAX_OUT_LEN;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {IDLE, HEADER, DATA, DONE} state_t;

  state_t              state_q, state_d;
  logic [6:0]          param_q, param_d;
  logic [3:0]          row_q, row_d;
  logic [WORD_W-1:0]   data_d;
  logic                valid_d, busy_d, done_d;
  logic [ROW_W-1:0]    row_bits;
  logic [ROW_W-1:0]    row_word;
  logic                accept;

  assign accept = uo_valid & ui_ready;

  // Select the row that will be on the bus next cycle.
  always_comb begin
    row_bits = '0;
    for (int unsigned i = 0; i < MAX_IN_LEN; i++) begin
      if (row_d == 4'(i)) row_bits = ui_weights[i*ROW_W +: ROW_W];
    end
  end

  // Mask unused columns and squash the illegal code 2'b10 to zero.
  always_comb begin
    row_word = '0;
    for (int unsigned j = 0; j < MAX_OUT_LEN; j++) begin
      if ((3'(j) <= param_d[2:0]) && (row_bits[2*j +: 2] != 2'b10))
        row_word[2*j +: 2] = row_bits[2*j +: 2];
    end
  end

  always_comb begin
    state_d = state_q;
    param_d = param_q;
    row_d   = row_q;
    data_d  = '0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (ena) begin
          state_d = HEADER;
          param_d = ui_param;
          row_d   = 4'd0;
        end
      end
      HEADER: begin
        if (!ena) begin
          state_d = IDLE;
        end else if (accept) begin
          state_d = DATA;
          row_d   = 4'd0;
        end
      end
      DATA: begin
        if (!ena) begin
          state_d = IDLE;
        end else if (accept) begin
          // Terminal compare precedes increment so the counter never wraps.
          if (row_q == param_q[6:3]) state_d = DONE;
          else                       row_d   = row_q + 4'd1;
        end
      end
      DONE: begin
        if (!ena) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      HEADER: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        data_d  = {4'h5, param_d, 5'b00000};
      end
      DATA: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        data_d  = WORD_W'(row_word);
      end
      DONE: begin
        busy_d = 1'b1;
        done_d = (state_q != DONE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      param_q  <= '0;
      row_q    <= '0;
      uo_data  <= '0;
      uo_valid <= 1'b0;
      uo_busy  <= 1'b0;
      uo_done  <= 1'b0;
    end else begin
      state_q  <= state_d;
      param_q  <= param_d;
      row_q    <= row_d;
      uo_data  <= data_d;
      uo_valid <= valid_d;
      uo_busy  <= busy_d;
      uo_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_tt_um_unload.sv
// Self-checking bench for tt_um_unload: word-list reference model compared
// every cycle, plus directed literal checks.
module tb_tt_um_unload;

  localparam int unsigned IN_LEN  = 16;
  localparam int unsigned OUT_LEN = 8;
  localparam int unsigned WW      = 2 * IN_LEN * OUT_LEN;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic [6:0]    ui_param;
  logic [WW-1:0] ui_weights;
  logic          ui_ready;
  logic [15:0]   uo_data;
  logic          uo_valid, uo_busy, uo_done;

  int total = 0;
  int bad   = 0;

  tt_um_unload #(.MAX_IN_LEN(IN_LEN), .MAX_OUT_LEN(OUT_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_param(ui_param),
    .ui_weights(ui_weights), .ui_ready(ui_ready), .uo_data(uo_data),
    .uo_valid(uo_valid), .uo_busy(uo_busy), .uo_done(uo_done)
  );

  always #5 clk = ~clk;

  // Reference model: a transfer is a list of words sent in order.
  logic [15:0] m_words [0:16];
  int          m_n = 0, m_idx = 0, m_mode = 0;
  logic        m_done = 1'b0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (!rst_n) begin
      m_mode = 0;
      chk_en = 1'b1;
    end else if (m_mode == 0) begin
      if (ena) begin
        m_n = int'(ui_param[6:3]) + 2;
        m_words[0] = 16'h5000 | (16'(ui_param) << 5);
        for (int i = 0; i < m_n - 1; i++) begin
          m_words[i+1] = 16'h0000;
          for (int j = 0; j <= int'(ui_param[2:0]); j++) begin
            logic [1:0] w;
            w = ui_weights[2*(i*OUT_LEN+j) +: 2];
            if (w != 2'b10) m_words[i+1] = m_words[i+1] | (16'(w) << (2*j));
          end
        end
        m_idx  = 0;
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (!ena) m_mode = 0;
      else if (ui_ready) begin
        if (m_idx == m_n - 1) begin
          m_mode = 2;
          m_done = 1'b1;
        end else m_idx++;
      end
    end else begin
      if (!ena) m_mode = 0;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [18:0] exp_v, got_v;
      exp_v = {(m_mode == 1) ? m_words[m_idx] : 16'h0000,
               m_mode == 1, m_mode != 0, m_done};
      got_v = {uo_data, uo_valid, uo_busy, uo_done};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL model_cmp t=%0t got data=%h v=%b b=%b d=%b required data=%h v=%b b=%b d=%b",
                 $time, got_v[18:3], got_v[2], got_v[1], got_v[0],
                 exp_v[18:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic set_w(input int i, input int j, input logic [1:0] v);
    ui_weights[2*(i*OUT_LEN+j) +: 2] = v;
  endtask

  task automatic fill_checker();
    for (int i = 0; i < IN_LEN; i++)
      for (int j = 0; j < OUT_LEN; j++)
        set_w(i, j, ((i + j) % 2 == 0) ? 2'b01 : 2'b11);
  endtask

  logic [15:0] cap [0:31];

  // Start a transfer, capture accepted words, optionally stall/abort/reset.
  task automatic run_xfer(input logic [6:0] p, input int abort_at, input int abort_kind,
                          input int stall_word, input bit rand_ready,
                          output int done_at, output int words);
    int stall_left;
    stall_left = 3;
    done_at = -1;
    words = 0;
    @(negedge clk);
    ui_param = p;
    ena = 1'b1;
    ui_ready = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (uo_done) begin
        done_at = k;
        break;
      end
      if (stall_word >= 0 && words == stall_word && stall_left > 0) begin
        ui_ready = 1'b0;
        stall_left--;
      end else ui_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (uo_valid && ui_ready) begin
        if (words < 32) cap[words] = uo_data;
        words++;
      end
      if (abort_at > 0 && words == abort_at) begin
        @(negedge clk);
        ena = 1'b0;
        if (abort_kind == 1) rst_n = 1'b0;
        return;
      end
    end
    if (done_at < 0) begin
      total++;
      bad++;
      $display("FAIL xfer_timeout got=no_done required=done param=%h", p);
    end
  endtask

  task automatic idle_cycles(input int n);
    ena = 1'b0;
    ui_ready = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int done_at, words;
    rst_n = 1'b0;
    ena = 1'b0;
    ui_param = '0;
    ui_weights = '0;
    ui_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_data", 32'(uo_data), 32'h0);
    chk("reset_flags", {29'd0, uo_valid, uo_busy, uo_done}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full 16x8 matrix, checkerboard weights, held ena through DONE.
    fill_checker();
    run_xfer(7'h7F, 0, 0, -1, 1'b0, done_at, words);
    chk("full_header", 32'(cap[0]), 32'h5FE0);
    chk("full_row0", 32'(cap[1]), 32'hDDDD);
    chk("full_row1", 32'(cap[2]), 32'h7777);
    chk("full_row15", 32'(cap[16]), 32'h7777);
    chk("full_words", 32'(words), 32'd17);
    chk("full_done_at", 32'(done_at), 32'd18);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_no_done", {30'd0, uo_done, uo_valid}, 32'h0);
    end
    idle_cycles(2);

    // Partial matrix, all +1.
    for (int i = 0; i < IN_LEN; i++)
      for (int j = 0; j < OUT_LEN; j++) set_w(i, j, 2'b01);
    run_xfer(7'b0010_011, 0, 0, -1, 1'b0, done_at, words);
    chk("part_header", 32'(cap[0]), 32'h5260);
    chk("part_row0", 32'(cap[1]), 32'h0055);
    chk("part_row2", 32'(cap[3]), 32'h0055);
    chk("part_words", 32'(words), 32'd4);
    chk("part_done_at", 32'(done_at), 32'd5);
    idle_cycles(2);

    // Backpressure during row 2.
    fill_checker();
    run_xfer(7'h7F, 0, 0, 3, 1'b0, done_at, words);
    chk("bp_row2", 32'(cap[3]), 32'hDDDD);
    chk("bp_row3", 32'(cap[4]), 32'h7777);
    chk("bp_words", 32'(words), 32'd17);
    chk("bp_done_at", 32'(done_at), 32'd21);
    idle_cycles(2);

    // Illegal code squashed to zero.
    ui_weights = '0;
    set_w(0, 0, 2'b10);
    run_xfer(7'h7F, 0, 0, -1, 1'b0, done_at, words);
    chk("illegal_row0", 32'(cap[1]), 32'h0000);
    idle_cycles(2);

    // Abort after row 1, then restart.
    fill_checker();
    run_xfer(7'h7F, 3, 0, -1, 1'b0, done_at, words);
    @(negedge clk);
    chk("abort_idle", {13'd0, uo_data, uo_valid, uo_busy, uo_done}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(uo_done), 32'h0);
    end
    run_xfer(7'h7F, 0, 0, -1, 1'b0, done_at, words);
    chk("restart_header", 32'(cap[0]), 32'h5FE0);
    chk("restart_words", 32'(words), 32'd17);
    idle_cycles(2);

    // Reset mid-DATA for one cycle, no restart while ena low.
    run_xfer(7'h7F, 4, 1, -1, 1'b0, done_at, words);
    @(negedge clk);
    chk("rst_outputs", {13'd0, uo_data, uo_valid, uo_busy, uo_done}, 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_no_restart", {30'd0, uo_busy, uo_valid}, 32'h0);
    end

    // Randomized transfers with random ready.
    for (int t = 0; t < 20; t++) begin
      logic [6:0] p;
      for (int c = 0; c < WW / 32; c++) ui_weights[c*32 +: 32] = $urandom;
      p = 7'($urandom);
      run_xfer(p, 0, 0, -1, 1'b1, done_at, words);
      chk("rand_words", 32'(words), 32'(int'(p[6:3]) + 2));
      idle_cycles(1 + $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
